// File: rtl/icache_axi_refill.sv
//------------------------------------------------------------------------------
// Module   : icache_axi_refill
// Purpose  : Single-outstanding icache line refill over one AXI4 INCR read burst.
//            Optional ICACHE_REFILL_ERR_EN adds the sticky line_err flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_axi_refill #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] ARID_VAL   = 4'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     line_valid,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                     line_err,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int                c_CNT_W = $clog2(LINE_WORDS);
  localparam int                c_OFF_W = $clog2(LINE_WORDS * 4);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(LINE_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:c_OFF_W]     r_addr;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [31:0]           r_words [LINE_WORDS];
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last_beat;

  assign req_ready  = (r_state == S_IDLE);
  assign arvalid    = (r_state == S_AR);
  assign rready     = (r_state == S_R);
  assign line_valid = (r_state == S_DONE);

  assign arid    = ARID_VAL;
  assign araddr  = {r_addr, {c_OFF_W{1'b0}}};
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign w_accept    = req_valid && req_ready;
  assign w_beat      = rvalid && rready;
  assign w_last_beat = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)             w_state_nxt = S_AR;
      S_AR:    if (arready)               w_state_nxt = S_R;
      S_R:     if (rvalid && w_last_beat) w_state_nxt = S_DONE;
      S_DONE:                             w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // Beat count saturates at the last slot; rlast never shortens the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < LINE_WORDS; k++) r_words[k] <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr[31:c_OFF_W];
        r_cnt  <= '0;
      end
      if (w_beat) begin
        if (!w_last_beat) r_cnt <= r_cnt + c_CNT_W'(1);
        for (int k = 0; k < LINE_WORDS; k++)
          if (r_cnt == c_CNT_W'(k)) r_words[k] <= rdata;
      end
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
    assign line_data[32*g +: 32] = r_words[g];
  end

`ifdef ICACHE_REFILL_ERR_EN
  logic r_err;
  logic w_unused;

  // Sticky across the burst: bad response or rlast not aligned with the final slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_beat && (rresp[1] || (rlast != w_last_beat))) begin
      r_err <= 1'b1;
    end
  end

  assign line_err = line_valid && r_err;
  assign w_unused = ^{rid, req_addr[c_OFF_W-1:0], rresp[0]};
`else
  logic w_unused;

  assign line_err = 1'b0;
  assign w_unused = ^{rid, req_addr[c_OFF_W-1:0], rresp, rlast};
`endif

endmodule

`default_nettype wire
